// File: rtl/tone_decoder_pkg.sv
// tone_pkg: keypad note table shared by the tone generator and tone_decoder.
package tone_pkg;
    localparam int NUM_NOTES = 13;
    localparam int HP_W = 11;
    // Half-period in ticks for each note and the keypad bit it represents.
    localparam logic [HP_W-1:0] NOTE_N [NUM_NOTES] = '{
        11'd498, 11'd1185, 11'd1119, 11'd996, 11'd444, 11'd395, 11'd373,
        11'd889, 11'd791, 11'd747, 11'd665, 11'd593, 11'd559
    };
    localparam logic [3:0] NOTE_BIT [NUM_NOTES] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9,
        4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };
endpackage

// File: rtl/tone_decoder_match.sv
// tone_match: combinational lookup of a half-period against the note table within +/-TOL ticks.
module tone_match
    import tone_pkg::*;
#(
    parameter int TOL = 8
) (
    input  logic [HP_W-1:0] half_period,
    output logic            hit,
    output logic [3:0]      idx,
    output logic [15:0]     onehot
);
    int d;
    always_comb begin
        hit = 1'b0;
        idx = '0;
        onehot = '0;
        d = 0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            d = int'(half_period) - int'(NOTE_N[i]);
            if (d >= -TOL && d <= TOL) begin
                hit = 1'b1;
                idx = 4'(i);
                onehot = 16'd1 << NOTE_BIT[i];
            end
        end
    end
endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: measures square-wave half-periods in ticks and decodes them to a one-hot key.
// TONE_DECODER_HOLD_EN: when defined, timeout keeps the last valid key and only raises silent.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int TICK_DIV = 100,
    parameter int TOL = 8,
    parameter int MATCH_CNT = 3,
    parameter int TIMEOUT = 1280
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sin,
    output logic [15:0]     keys,
    output logic            key_valid,
    output logic [HP_W-1:0] half_period,
    output logic            silent
);
`ifdef TONE_DECODER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam int PW = $clog2(TICK_DIV);
    logic s1, s2, s3, tone_edge, tick, to_evt, armed, smp, hit, same;
    logic [PW-1:0] presc;
    logic [HP_W-1:0] cnt;
    logic [2:0] run, run_n;
    logic [3:0] idx, last_idx;
    logic [15:0] onehot, key_oh;
    tone_match #(.TOL(TOL)) u_match (
        .half_period(half_period),
        .hit(hit),
        .idx(idx),
        .onehot(onehot)
    );
    assign tone_edge = s2 ^ s3;
    assign tick = presc == PW'(TICK_DIV - 1);
    assign to_evt = tick && !tone_edge && cnt == HP_W'(TIMEOUT - 1);
    assign key_valid = run == 3'(MATCH_CNT);
    assign keys = key_valid ? key_oh : '0;
    always_comb begin
        same = run != 3'd0 && idx == last_idx;
        run_n = !hit ? 3'd0 : !same ? 3'd1 : key_valid ? run : run + 3'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s3, armed, smp} <= '0;
            presc <= '0;
            cnt <= '0;
            run <= '0;
            last_idx <= '0;
            key_oh <= '0;
            half_period <= '0;
            silent <= 1'b1;
        end else begin
            s1 <= sin;
            s2 <= s1;
            s3 <= s2;
            presc <= (tone_edge || tick) ? '0 : presc + 1'b1;
            // An edge coinciding with a tick captures the pre-increment count.
            cnt <= tone_edge ? '0 : (tick && cnt != HP_W'(TIMEOUT)) ? cnt + 1'b1 : cnt;
            smp <= tone_edge && armed;
            if (tone_edge) begin
                armed <= 1'b1;
                silent <= 1'b0;
                if (armed) half_period <= cnt;
            end else if (to_evt) begin
                armed <= 1'b0;
                silent <= 1'b1;
                if (!HOLD) run <= '0;
            end
            if (smp) begin
                run <= run_n;
                last_idx <= idx;
                key_oh <= onehot;
            end
        end
    end
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed-vector bench for tone_decoder, run with a 2-clk tick to keep runs short.
module tb_tone_decoder;
    localparam int TD = 2;
    logic clk = 1'b0, rst = 1'b1, sin = 1'b0;
    logic [15:0] keys;
    logic key_valid, silent;
    logic [10:0] half_period;
    int checks = 0, failures = 0;
    tone_decoder #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .sin(sin), .keys(keys),
        .key_valid(key_valid), .half_period(half_period), .silent(silent)
    );
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Toggle then wait 4 clk: outputs reflect the sample closed by this toggle.
    task automatic tog();
        sin = ~sin;
        wait_clk(4);
    endtask
    // Finish the gap so toggle spacing is n*TD+1 clk, which measures exactly n ticks.
    task automatic rest(input int n);
        wait_clk(n * TD - 3);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        sin = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
    endtask
    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        checks++;
        if (keys !== 16'h0 || key_valid !== 1'b0 || half_period !== 11'd0 || silent !== 1'b1) begin
            failures++;
            $display("FAIL reset_vals keys=%h valid=%b hp=%0d silent=%b exp 0000/0/0/1", keys, key_valid, half_period, silent);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_clk(100);
            checks++;
            if (silent !== 1'b1 || key_valid !== 1'b0 || keys !== 16'h0) begin
                failures++;
                $display("FAIL silence_%0d silent=%b valid=%b keys=%h exp 1/0/0000", i, silent, key_valid, keys);
            end
        end
    endtask
    task automatic test_lock_498();
        do_reset();
        tog(); rest(498);
        tog(); rest(498);
        tog(); rest(498);
        sin = ~sin;
        wait_clk(3);
        checks++;
        if (key_valid !== 1'b0 || half_period !== 11'd498) begin
            failures++;
            $display("FAIL lock498_pre valid=%b hp=%0d exp 0/498", key_valid, half_period);
        end
        wait_clk(1);
        checks++;
        if (key_valid !== 1'b1 || keys !== 16'h0001) begin
            failures++;
            $display("FAIL lock498 valid=%b keys=%h exp 1/0001", key_valid, keys);
        end
        rest(498);
        tog();
        checks++;
        if (key_valid !== 1'b1 || keys !== 16'h0001 || half_period !== 11'd498 || silent !== 1'b0) begin
            failures++;
            $display("FAIL lock498_hold valid=%b keys=%h hp=%0d silent=%b", key_valid, keys, half_period, silent);
        end
    endtask
    task automatic test_switch();
        do_reset();
        for (int i = 0; i < 4; i++) begin tog(); rest(380); end
        tog();
        checks++;
        if (key_valid !== 1'b1 || keys !== 16'h0200 || half_period !== 11'd380) begin
            failures++;
            $display("FAIL sw380 valid=%b keys=%h hp=%0d exp 1/0200/380", key_valid, keys, half_period);
        end
        rest(400);
        for (int i = 0; i < 2; i++) begin
            tog();
            checks++;
            if (key_valid !== 1'b0 || keys !== 16'h0) begin
                failures++;
                $display("FAIL sw_drop_%0d valid=%b keys=%h exp 0/0000", i, key_valid, keys);
            end
            rest(400);
        end
        tog();
        checks++;
        if (key_valid !== 1'b1 || keys !== 16'h0100 || half_period !== 11'd400) begin
            failures++;
            $display("FAIL sw400 valid=%b keys=%h hp=%0d exp 1/0100/400", key_valid, keys, half_period);
        end
    endtask
    task automatic test_nomatch();
        do_reset();
        for (int i = 0; i < 3; i++) begin tog(); rest(665); end
        tog();
        checks++;
        if (key_valid !== 1'b1 || keys !== 16'h2000) begin
            failures++;
            $display("FAIL nm665 valid=%b keys=%h exp 1/2000", key_valid, keys);
        end
        rest(665);
        tog(); rest(420);
        sin = ~sin;
        wait_clk(3);
        checks++;
        if (key_valid !== 1'b1 || half_period !== 11'd420) begin
            failures++;
            $display("FAIL nm_e1 valid=%b hp=%0d exp 1/420", key_valid, half_period);
        end
        wait_clk(1);
        checks++;
        if (key_valid !== 1'b0 || keys !== 16'h0) begin
            failures++;
            $display("FAIL nm_drop valid=%b keys=%h exp 0/0000", key_valid, keys);
        end
        rest(420);
        tog();
        checks++;
        if (key_valid !== 1'b0 || keys !== 16'h0 || half_period !== 11'd420) begin
            failures++;
            $display("FAIL nm420 valid=%b keys=%h hp=%0d exp 0/0000/420", key_valid, keys, half_period);
        end
    endtask
    task automatic test_timeout();
        logic [15:0] exp_keys;
        logic exp_valid;
`ifdef TONE_DECODER_HOLD_EN
        exp_keys = 16'h8000;
        exp_valid = 1'b1;
`else
        exp_keys = 16'h0;
        exp_valid = 1'b0;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin tog(); rest(559); end
        tog();
        checks++;
        if (key_valid !== 1'b1 || keys !== 16'h8000 || half_period !== 11'd559) begin
            failures++;
            $display("FAIL to559 valid=%b keys=%h hp=%0d exp 1/8000/559", key_valid, keys, half_period);
        end
        wait_clk(1280 * TD - 14);
        checks++;
        if (silent !== 1'b0 || key_valid !== 1'b1) begin
            failures++;
            $display("FAIL to_before silent=%b valid=%b exp 0/1", silent, key_valid);
        end
        wait_clk(20);
        checks++;
        if (silent !== 1'b1 || keys !== exp_keys || key_valid !== exp_valid) begin
            failures++;
            $display("FAIL to_after silent=%b keys=%h valid=%b exp 1/%h/%b", silent, keys, key_valid, exp_keys, exp_valid);
        end
        tog();
        checks++;
        if (silent !== 1'b0 || half_period !== 11'd559 || keys !== exp_keys) begin
            failures++;
            $display("FAIL to_rearm silent=%b hp=%0d keys=%h exp 0/559/%h", silent, half_period, keys, exp_keys);
        end
    endtask
    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin tog(); rest(747); end
        tog();
        checks++;
        if (key_valid !== 1'b1 || keys !== 16'h1000) begin
            failures++;
            $display("FAIL rm747 valid=%b keys=%h exp 1/1000", key_valid, keys);
        end
        wait_clk(100);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        checks++;
        if (keys !== 16'h0 || key_valid !== 1'b0 || half_period !== 11'd0 || silent !== 1'b1) begin
            failures++;
            $display("FAIL rm_reset keys=%h valid=%b hp=%0d silent=%b exp 0000/0/0/1", keys, key_valid, half_period, silent);
        end
        wait_clk(3);
        checks++;
        if (key_valid !== 1'b0 || silent !== 1'b1) begin
            failures++;
            $display("FAIL rm_release valid=%b silent=%b exp 0/1", key_valid, silent);
        end
        tog();
        checks++;
        if (half_period !== 11'd0 || silent !== 1'b0 || key_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_discard hp=%0d silent=%b valid=%b exp 0/0/0", half_period, silent, key_valid);
        end
        rest(747);
        for (int i = 0; i < 2; i++) begin
            tog();
            checks++;
            if (key_valid !== 1'b0 || half_period !== 11'd747) begin
                failures++;
                $display("FAIL rm_relock_%0d valid=%b hp=%0d exp 0/747", i, key_valid, half_period);
            end
            rest(747);
        end
        tog();
        checks++;
        if (key_valid !== 1'b1 || keys !== 16'h1000) begin
            failures++;
            $display("FAIL rm_relock valid=%b keys=%h exp 1/1000", key_valid, keys);
        end
    endtask
    initial begin
        test_reset();
        test_lock_498();
        test_switch();
        test_nomatch();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receive-side counterpart of the key-to-tone path.
- Measures half-periods of an incoming square-wave tone, such as the speaker PWM envelope or a test generator, in units of the audio tick.
- Matches each half-period against the 13-entry keypad note table and reconstructs the 16-bit one-hot key vector.
- Used for loopback self-test of the keypad/audio path and as a remote tone-to-key front end.

Parameters:
- TICK_DIV, 100: clk cycles per tick; must equal the tone generator's tick.
- TOL, 8: ± tick tolerance for a table match; must be < 11, half the minimum table spacing of 22 (373 vs 395).
- MATCH_CNT, 3: consecutive same-key half-periods required before asserting valid; range 1..7.
- TIMEOUT, 1280: tick count with no edge at which silence is declared; ≤ 2047.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sin  in  1  asynchronous tone input
- keys  out  16  one-hot decoded key; all zero when invalid
- key_valid  out  1  stable tone matched
- half_period  out  11  last captured half-period in ticks
- silent  out  1  timeout active, no tone present

Behaviour:
- Synchronisation and edge detection:
  - sin passes through 2 flops (s1, s2), then a third flop s3.
  - edge = s2 ^ s3; both polarities count.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits tick on the wrap.
  - Cleared to 0 on edge.
- Period counter cnt (11 bits):
  - Increments on tick.
  - Saturates at TIMEOUT.
  - Cleared on edge in the same cycle the value is captured.
  - An edge with simultaneous tick captures cnt, not cnt+1.
- Capture on edge cycle E:
  - half_period <= cnt at E+1.
  - armed must be 1 for the sample to be used.
  - The first edge after reset or after timeout only sets armed and starts measurement; that sample is discarded and half_period is not updated.
- Match at E+1, combinational from half_period:
  - idx = table entry with |half_period − N_i| ≤ TOL.
  - Tolerance is unique by construction, so there is no priority conflict.
- Run counter at E+2 (3 bits):
  - Same idx as previous sample: run <= min(run+1, MATCH_CNT).
  - Different matched idx: run <= 1.
  - No match: run <= 0.
- Outputs at E+2:
  - key_valid = (run == MATCH_CNT); keys = onehot(idx) when valid, else 0.
  - A no-match sample drops valid/keys at E+2.
  - Total latency from the completing edge on s2 to valid output is 2 clk. From the sin pin it is 4 clk.
- Timeout:
  - The cycle cnt reaches TIMEOUT: silent <= 1, armed <= 0, run <= 0, key_valid <= 0, keys <= 0.
  - silent clears on the next edge.
- Reset values:
  - keys = 0, key_valid = 0, half_period = 0, silent = 1.
  - Internal: armed = 0, run = 0, cnt = 0, prescaler = 0, s1/s2/s3 = 0.
  - Reset mid-measurement discards everything; no output glitch after release.
- Key/N table, one-hot bit: N
  - 0:498, 1:1185, 2:1119, 3:996, 7:444, 8:395, 9:373, 10:889, 11:791, 12:747, 13:665, 14:593, 15:559.
  - Bits 4..6 are never driven.

Optional Feature:
- Macro: TONE_DECODER_HOLD_EN.
- Defined: on timeout, keys/key_valid hold their last valid value and only silent asserts. A subsequent no-match sample or a different-key run still updates normally.
- Undefined: timeout clears keys/key_valid as above.

Decomposition:
- Package tone_pkg:
  - NUM_NOTES = 13.
  - Note table arrays NOTE_N[13] and NOTE_BIT[13].
  - Half-period width constant HP_W = 11.
  - Shared with the tone generator so both ends use one table.
- Sub-module tone_match:
  - Purely combinational: half_period → hit, idx, onehot.
  - Instantiated once; unit-testable against the table.

Test Plan:
- Reset, then silence for 2000 ticks -> silent = 1, keys = 0, key_valid = 0 throughout.
- Square wave with half-period 498 ticks, 5 half-periods -> half_period = 498; key_valid rises 2 clk after the 4th edge (the 1st is discarded, then 3 matches); keys = 16'h0001.
- Half-period 380 (within TOL of 373), then switch to 400 (within TOL of 395) -> keys = 16'h0200; after the switch, valid drops for 2 samples, then keys = 16'h0100.
- Half-period 420 (no entry within ±8) -> key_valid = 0, keys = 0; half_period = 420 still reported.
- Stable key 15 (559), then sin held -> after 1280 ticks, silent = 1 and keys = 0; with TONE_DECODER_HOLD_EN, keys stays 16'h8000.
- rst asserted for 1 clk mid-tone at key 12 (747) -> all outputs reset next cycle; re-lock after 1 discarded plus 3 valid edges.
